// File: rtl/ft601_bus_model.sv
// FT601 chip-side model of the 245 synchronous FIFO bus.
// Down FIFO: host -> USB read path; up FIFO: USB writes -> host.
module ft601_bus_model #(
   parameter int DEPTH        = 16,
   parameter int PACKET_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_l,
   input  logic [PACKET_WIDTH-1:0] usb_data_in,
   input  logic [3:0]              usb_be_in,
   output logic [PACKET_WIDTH-1:0] usb_data_out,
   output logic [3:0]              usb_be_out,
   output logic                    usb_data_oe,
   output logic                    usb_tx_full,
   output logic                    usb_rx_empty,
   input  logic                    usb_wren_l,
   input  logic                    usb_rden_l,
   input  logic                    usb_outen_l,
   input  logic                    usb_rst_l,
   input  logic [PACKET_WIDTH-1:0] host_wr_data,
   input  logic [3:0]              host_wr_be,
   input  logic                    host_wr_valid,
   output logic                    host_wr_ready,
   output logic [PACKET_WIDTH-1:0] host_rd_data,
   output logic [3:0]              host_rd_be,
   output logic                    host_rd_valid,
   input  logic                    host_rd_ready,
   output logic                    err_underrun,
   output logic                    err_overrun,
   output logic                    err_protocol
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = PACKET_WIDTH + 4;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_TURN,
      RD_STREAM
   } rd_state_e;

   rd_state_e state_q;

   logic [EW-1:0] dn_mem [DEPTH];
   logic [EW-1:0] up_mem [DEPTH];
   logic [AW-1:0] dn_wp_q, dn_rp_q;
   logic [AW-1:0] up_wp_q, up_rp_q;
   logic [CW-1:0] dn_cnt_q, up_cnt_q;
   logic          err_u_q, err_o_q, err_p_q;

   logic wr_act, rd_act, oe_act;
   logic dn_empty, up_empty, up_full, rd_open;
   logic viol, up_push, up_pop, dn_push, dn_pop;

   assign wr_act   = ~usb_wren_l;
   assign rd_act   = ~usb_rden_l;
   assign oe_act   = ~usb_outen_l;
   assign dn_empty = (dn_cnt_q == '0);
   assign up_empty = (up_cnt_q == '0);
   assign up_full  = (up_cnt_q == CW'(DEPTH));
   assign rd_open  = (state_q != RD_IDLE);

   // Any sequencing violation also blocks the push/pop it would cause.
   assign viol    = (rd_act & ~rd_open) | (wr_act & oe_act)
                  | (wr_act & rd_act);
   assign up_push = wr_act & ~up_full & ~oe_act & ~rd_act;
   assign dn_pop  = rd_open & rd_act & oe_act & ~wr_act & ~dn_empty;
   assign dn_push = host_wr_valid & host_wr_ready;
   assign up_pop  = host_rd_valid & host_rd_ready;

   assign usb_data_oe   = oe_act;
   assign usb_tx_full   = up_full;
   assign usb_rx_empty  = dn_empty;
   assign host_wr_ready = (dn_cnt_q < CW'(DEPTH));
   assign host_rd_valid = ~up_empty;
   assign err_underrun  = err_u_q;
   assign err_overrun   = err_o_q;
   assign err_protocol  = err_p_q;

   assign {usb_be_out, usb_data_out} = dn_empty ? '0 : dn_mem[dn_rp_q];
   assign {host_rd_be, host_rd_data} = up_empty ? '0 : up_mem[up_rp_q];

   always_ff @(posedge clk) begin
      if (dn_push) dn_mem[dn_wp_q] <= {host_wr_be, host_wr_data};
      if (up_push) up_mem[up_wp_q] <= {usb_be_in, usb_data_in};
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= RD_IDLE;
         dn_wp_q  <= '0;
         dn_rp_q  <= '0;
         up_wp_q  <= '0;
         up_rp_q  <= '0;
         dn_cnt_q <= '0;
         up_cnt_q <= '0;
         err_u_q  <= 1'b0;
         err_o_q  <= 1'b0;
         err_p_q  <= 1'b0;
      end else if (!usb_rst_l) begin
         state_q  <= RD_IDLE;
         dn_wp_q  <= '0;
         dn_rp_q  <= '0;
         up_wp_q  <= '0;
         up_rp_q  <= '0;
         dn_cnt_q <= '0;
         up_cnt_q <= '0;
         err_u_q  <= 1'b0;
         err_o_q  <= 1'b0;
         err_p_q  <= 1'b0;
      end else begin
         if (dn_push) dn_wp_q <= dn_wp_q + AW'(1);
         if (dn_pop)  dn_rp_q <= dn_rp_q + AW'(1);
         if (up_push) up_wp_q <= up_wp_q + AW'(1);
         if (up_pop)  up_rp_q <= up_rp_q + AW'(1);
         dn_cnt_q <= dn_cnt_q + CW'(dn_push) - CW'(dn_pop);
         up_cnt_q <= up_cnt_q + CW'(up_push) - CW'(up_pop);
         if (viol)                       err_p_q <= 1'b1;
         if (wr_act & up_full)           err_o_q <= 1'b1;
         if (rd_act & rd_open & dn_empty) err_u_q <= 1'b1;
         if (!oe_act) begin
            state_q <= RD_IDLE;
         end else begin
            unique case (state_q)
               RD_IDLE:   state_q <= RD_TURN;
               RD_TURN:   if (rd_act) state_q <= RD_STREAM;
               RD_STREAM: state_q <= RD_STREAM;
               default:   state_q <= RD_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ft601_bus_model.sv
// Bench for ft601_bus_model: directed bus scenarios plus random
// traffic, each cycle checked against a queue-based bus model.
module tb_ft601_bus_model;
   localparam int D = 16;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_l = 1'b0;
   logic [W-1:0] usb_data_in = '0;
   logic [3:0]   usb_be_in = '0;
   logic [W-1:0] usb_data_out;
   logic [3:0]   usb_be_out;
   logic         usb_data_oe, usb_tx_full, usb_rx_empty;
   logic         usb_wren_l = 1'b1;
   logic         usb_rden_l = 1'b1;
   logic         usb_outen_l = 1'b1;
   logic         usb_rst_l = 1'b1;
   logic [W-1:0] host_wr_data = '0;
   logic [3:0]   host_wr_be = '0;
   logic         host_wr_valid = 1'b0;
   logic         host_wr_ready;
   logic [W-1:0] host_rd_data;
   logic [3:0]   host_rd_be;
   logic         host_rd_valid;
   logic         host_rd_ready = 1'b0;
   logic         err_underrun, err_overrun, err_protocol;

   ft601_bus_model #(.DEPTH(D), .PACKET_WIDTH(W)) dut (
      .clk(clk), .rst_l(rst_l),
      .usb_data_in(usb_data_in), .usb_be_in(usb_be_in),
      .usb_data_out(usb_data_out), .usb_be_out(usb_be_out),
      .usb_data_oe(usb_data_oe), .usb_tx_full(usb_tx_full),
      .usb_rx_empty(usb_rx_empty), .usb_wren_l(usb_wren_l),
      .usb_rden_l(usb_rden_l), .usb_outen_l(usb_outen_l),
      .usb_rst_l(usb_rst_l), .host_wr_data(host_wr_data),
      .host_wr_be(host_wr_be), .host_wr_valid(host_wr_valid),
      .host_wr_ready(host_wr_ready), .host_rd_data(host_rd_data),
      .host_rd_be(host_rd_be), .host_rd_valid(host_rd_valid),
      .host_rd_ready(host_rd_ready), .err_underrun(err_underrun),
      .err_overrun(err_overrun), .err_protocol(err_protocol)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Model: bus ownership phase 0=idle, 1=turnaround, 2=streaming.
   logic [35:0] dn_q[$];
   logic [35:0] up_q[$];
   int          ph = 0;
   bit          m_eu = 0, m_eo = 0, m_ep = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic compare();
      logic [35:0] dh, uh;
      dh = (dn_q.size() > 0) ? dn_q[0] : 36'h0;
      uh = (up_q.size() > 0) ? up_q[0] : 36'h0;
      chk("rx_empty", usb_rx_empty, dn_q.size() == 0);
      chk("tx_full", usb_tx_full, up_q.size() == D);
      chk("data_oe", usb_data_oe, !usb_outen_l);
      chk("usb_out", {usb_be_out, usb_data_out}, dh);
      chk("wr_ready", host_wr_ready, dn_q.size() < D);
      chk("rd_valid", host_rd_valid, up_q.size() > 0);
      chk("host_out", {host_rd_be, host_rd_data}, uh);
      chk("err_u", err_underrun, m_eu);
      chk("err_o", err_overrun, m_eo);
      chk("err_p", err_protocol, m_ep);
   endtask

   task automatic step();
      bit rx_e, tx_f, w, r, o, hpush, hpop;
      logic [35:0] tmp;
      rx_e  = (dn_q.size() == 0);
      tx_f  = (up_q.size() == D);
      w     = !usb_wren_l;
      r     = !usb_rden_l;
      o     = !usb_outen_l;
      hpush = host_wr_valid && (dn_q.size() < D);
      hpop  = host_rd_ready && (up_q.size() > 0);
      if (!usb_rst_l) begin
         dn_q.delete();
         up_q.delete();
         ph = 0;
         m_eu = 0; m_eo = 0; m_ep = 0;
      end else begin
         if ((r && ph == 0) || (w && o) || (w && r)) m_ep = 1;
         if (w && tx_f) m_eo = 1;
         if (r && ph != 0 && rx_e) m_eu = 1;
         if (ph != 0 && r && o && !w && !rx_e) tmp = dn_q.pop_front();
         if (hpush) dn_q.push_back({host_wr_be, host_wr_data});
         if (hpop) tmp = up_q.pop_front();
         if (w && !tx_f && !o && !r)
            up_q.push_back({usb_be_in, usb_data_in});
         if (!o) ph = 0;
         else if (ph == 0) ph = 1;
         else if (ph == 1 && r) ph = 2;
      end
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic bus_clear();
      usb_rst_l = 1'b0;
      step();
      usb_rst_l = 1'b1;
   endtask

   initial begin
      #1;
      compare();
      @(negedge clk);
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      compare();

      // host -> FPGA stream of four words
      host_wr_be = 4'hF;
      for (int i = 1; i <= 4; i++) begin
         host_wr_valid = 1'b1;
         host_wr_data = W'(i);
         step();
      end
      host_wr_valid = 1'b0;
      usb_outen_l = 1'b0;
      step();
      usb_rden_l = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("stream%0d", i), usb_data_out, i);
         step();
      end
      chk("stream_empty", usb_rx_empty, 1);
      usb_rden_l = 1'b1;
      usb_outen_l = 1'b1;
      step();
      chk("stream_noerr", {err_underrun, err_overrun, err_protocol}, 0);

      // FPGA -> host fill to full, overrun, drain
      usb_be_in = 4'hF;
      usb_wren_l = 1'b0;
      for (int i = 0; i < D; i++) begin
         usb_data_in = 32'hA000_0000 + W'(i);
         step();
         if (i == D - 2) chk("not_full", usb_tx_full, 0);
      end
      chk("full", usb_tx_full, 1);
      usb_data_in = 32'hDEAD_BEEF;
      step();
      usb_wren_l = 1'b1;
      chk("overrun", err_overrun, 1);
      host_rd_ready = 1'b1;
      for (int i = 0; i < D; i++) begin
         chk($sformatf("drain%0d", i), host_rd_data,
             32'hA000_0000 + i);
         step();
      end
      chk("drain_valid", host_rd_valid, 0);
      host_rd_ready = 1'b0;

      // full down FIFO, host push blocked while master pops
      bus_clear();
      for (int i = 0; i < D; i++) begin
         host_wr_valid = 1'b1;
         host_wr_data = 32'hB0 + W'(i);
         step();
      end
      chk("dn_full_rdy", host_wr_ready, 0);
      host_wr_data = 32'hC0;
      usb_outen_l = 1'b0;
      step();
      usb_rden_l = 1'b0;
      step();
      chk("rdy_rise", host_wr_ready, 1);
      usb_rden_l = 1'b1;
      step();
      host_wr_valid = 1'b0;
      usb_rden_l = 1'b0;
      for (int i = 1; i <= D; i++) begin
         chk($sformatf("tail%0d", i), usb_data_out,
             (i == D) ? 32'hC0 : 32'hB0 + i);
         step();
      end
      usb_rden_l = 1'b1;
      usb_outen_l = 1'b1;
      step();

      // read strobe in idle
      bus_clear();
      host_wr_valid = 1'b1;
      host_wr_data = 32'h55;
      step();
      host_wr_valid = 1'b0;
      usb_rden_l = 1'b0;
      step();
      usb_rden_l = 1'b1;
      chk("idle_rd_p", err_protocol, 1);
      chk("idle_rd_nopop", usb_rx_empty, 0);

      // underrun while streaming
      bus_clear();
      usb_outen_l = 1'b0;
      step();
      usb_rden_l = 1'b0;
      step();
      step();
      chk("underrun", err_underrun, 1);
      chk("underrun_p", err_protocol, 0);
      usb_rden_l = 1'b1;
      usb_outen_l = 1'b1;
      step();

      // write during output enable
      bus_clear();
      usb_outen_l = 1'b0;
      usb_wren_l = 1'b0;
      step();
      usb_wren_l = 1'b1;
      usb_outen_l = 1'b1;
      chk("contend_p", err_protocol, 1);
      chk("contend_nopush", host_rd_valid, 0);
      step();

      // usb_rst_l mid read burst with five words each way
      bus_clear();
      for (int i = 0; i < 5; i++) begin
         host_wr_valid = 1'b1;
         host_wr_data = 32'h100 + W'(i);
         usb_wren_l = 1'b0;
         usb_data_in = 32'h200 + W'(i);
         step();
      end
      host_wr_valid = 1'b0;
      usb_wren_l = 1'b1;
      usb_outen_l = 1'b0;
      step();
      usb_rden_l = 1'b0;
      step();
      usb_rst_l = 1'b0;
      step();
      usb_rst_l = 1'b1;
      chk("rst_rx_empty", usb_rx_empty, 1);
      chk("rst_rd_valid", host_rd_valid, 0);
      chk("rst_data", usb_data_out, 0);
      chk("rst_errs", {err_underrun, err_overrun, err_protocol}, 0);
      step();
      chk("rst_fsm_idle", err_protocol, 1);
      usb_rden_l = 1'b1;
      usb_outen_l = 1'b1;
      step();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(7) == 0) usb_outen_l = ~usb_outen_l;
         if (!usb_outen_l) begin
            usb_rden_l = ($urandom_range(3) == 0);
            usb_wren_l = ($urandom_range(40) != 0);
         end else begin
            usb_rden_l = ($urandom_range(40) != 0);
            usb_wren_l = ($urandom_range(2) == 0);
         end
         usb_data_in   = $urandom;
         usb_be_in     = 4'($urandom);
         host_wr_data  = $urandom;
         host_wr_be    = 4'($urandom);
         host_wr_valid = ($urandom_range(1) == 1);
         host_rd_ready = ($urandom_range(2) == 0);
         usb_rst_l     = ($urandom_range(300) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ft601_bus_model.md
Name: ft601_bus_model

Overview:
- Synthesizable model of the FT601 chip side of the 245-synchronous FIFO bus: the slave end of the interface that the FPGA-side FT601 controller drives as master.
- Holds two word FIFOs:
  - Down: host to FPGA, presented on the USB read path.
  - Up: FPGA to host, filled by USB writes.
- Each FIFO exposes a valid/ready host-side stream.
- Used for loopback builds and as the DUT-facing partner in system benches, replacing the physical FT601.

Parameters:
- DEPTH, 16, words per FIFO; power of 2, >=2.
- PACKET_WIDTH, 32, data bus width; matches usb_packet_width.

Ports:
- clk  in  1  bus clock (the FT601 CLK)
- rst_l  in  1  asynchronous active-low reset
- usb_data_in  in  PACKET_WIDTH  data driven by master during writes
- usb_be_in  in  4  byte enables driven by master during writes
- usb_data_out  out  PACKET_WIDTH  data driven toward master during reads
- usb_be_out  out  4  byte enables toward master during reads
- usb_data_oe  out  1  1 = model drives data/be (tristate enable for the top-level IOBUF)
- usb_tx_full  out  1  1 = up FIFO full
- usb_rx_empty  out  1  1 = down FIFO empty
- usb_wren_l  in  1  master write strobe, active low
- usb_rden_l  in  1  master read strobe, active low
- usb_outen_l  in  1  master output-enable request, active low
- usb_rst_l  in  1  master-issued chip reset, active low, sampled synchronously
- host_wr_data  in  PACKET_WIDTH  host word destined for the FPGA
- host_wr_be  in  4  byte enables for host_wr_data
- host_wr_valid  in  1  host word valid
- host_wr_ready  out  1  down FIFO can accept
- host_rd_data  out  PACKET_WIDTH  word written by the FPGA
- host_rd_be  out  4  byte enables for host_rd_data
- host_rd_valid  out  1  up FIFO non-empty
- host_rd_ready  in  1  host consumes word
- err_underrun  out  1  sticky: read strobe while down FIFO empty
- err_overrun  out  1  sticky: write strobe while usb_tx_full
- err_protocol  out  1  sticky: bus sequencing violation

Behaviour:
- Reset (rst_l low, asynchronous): both FIFOs empty; read FSM = RD_IDLE; all error flags 0. Outputs:
  - usb_rx_empty=1, usb_tx_full=0, usb_data_oe=0.
  - usb_data_out=0, usb_be_out=0.
  - host_wr_ready=1, host_rd_valid=0, host_rd_data=0, host_rd_be=0.
- usb_rst_l low at a clock edge: same state as reset, applied synchronously; it holds while low.
- Registered status: usb_tx_full, usb_rx_empty, host_wr_ready and host_rd_valid derive only from registered FIFO counts.
  - usb_tx_full = (up count == DEPTH); usb_rx_empty = (down count == 0).
  - The only combinational input-to-output path is usb_data_oe = ~usb_outen_l.
- FIFO storage: each FIFO stores {be, data} together. Head word is first-word-fall-through:
  - usb_data_out/usb_be_out show the down head.
  - host_rd_data/host_rd_be show the up head.
  - Both are 0 when the FIFO is empty.
- USB write: on an edge with usb_wren_l=0 and usb_tx_full=0, push {usb_be_in, usb_data_in} into the up FIFO.
  - Byte enable 0000 is stored unchanged.
  - wren_l=0 with usb_tx_full=1: word dropped, err_overrun set.
- Read FSM:
  - RD_IDLE -> RD_TURN when usb_outen_l=0.
  - RD_TURN -> RD_STREAM on an edge with usb_rden_l=0.
  - RD_TURN or RD_STREAM -> RD_IDLE when usb_outen_l=1.
- Pops:
  - Pop the down FIFO on each edge where state is RD_TURN or RD_STREAM, usb_rden_l=0, usb_outen_l=0 and the FIFO is non-empty.
  - The next head word appears the following cycle, so a back-to-back stream delivers one word per clock.
  - rden_l=0 while empty: no pop, err_underrun set.
- err_protocol is set by any of:
  - rden_l=0 in RD_IDLE;
  - wren_l=0 while outen_l=0 (bus contention);
  - wren_l=0 and rden_l=0 in the same cycle.
  - In all three cases the offending push or pop is suppressed.
- Host write: push when host_wr_valid && host_wr_ready; host_wr_ready = (down count < DEPTH).
- Host read: pop when host_rd_valid && host_rd_ready.
- Simultaneous push and pop on one FIFO in the same cycle: both take effect and the count is unchanged. A pop on an empty FIFO is never performed.
- Pointers: wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits, so full and empty are distinguished.
- Error flags clear only by reset or usb_rst_l.

Test Plan:
- Reset then idle: after rst_l rises, check usb_rx_empty=1, usb_tx_full=0, usb_data_oe=0, host_wr_ready=1, host_rd_valid=0, all errors 0.
- Host-to-FPGA stream:
  - Stimulus: host pushes 0x0000_0001..0x0000_0004 with be=1111; master drives outen_l=0, then rden_l=0 for 4 cycles.
  - Required: words read back in order, one per clock; usb_rx_empty=1 one cycle after the last pop; no errors.
- FPGA-to-host fill to full:
  - Stimulus: master writes DEPTH words 0xA000_0000+i with host_rd_ready=0.
  - Required: usb_tx_full=1 after word 16. A 17th write sets err_overrun and is dropped. Draining returns exactly 16 words in order, with host_rd_valid falling after the last.
- Simultaneous push/pop on a full down FIFO:
  - Stimulus: host push with ready=0 while the master pops.
  - Required: count goes 16->15; host_wr_ready rises the next cycle; the next accepted host word lands at tail.
- Protocol violations:
  - rden_l=0 in RD_IDLE -> err_protocol=1 and no pop.
  - rden_l=0 on an empty down FIFO in RD_STREAM -> err_underrun=1.
  - wren_l=0 with outen_l=0 -> err_protocol=1 and no push.
- usb_rst_l mid-stream:
  - Stimulus: with 5 words queued each way, pulse usb_rst_l low for one cycle during a read burst.
  - Required: both FIFOs empty, FSM = RD_IDLE, errors cleared, usb_data_out=0.
